multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle control FSM for the RV32I core: fetches an instruction over a req/ack port,
//  latches it, decodes every RV32I base opcode and sequences EXEC/MEM/WB, driving ALU,
//  immediate, register-file, PC and data-memory controls. Adds branch-condition evaluation,
//  wait-state memory handshakes, a memory timeout counter and an illegal-opcode trap.
// PARAMETERS
//  ADDRESS_WIDTH  32  instruction width (must be 32 for RV32I)
//  MEM_TIMEOUT    15  max wait cycles for imem/dmem ack before trap (1..255)
// PORTS
//  clk_i          in   1   clock, all state on rising edge
//  rst_ni         in   1   reset, synchronous, active-low
//  imem_req_o     out  1   instruction fetch request
//  imem_ack_i     in   1   fetch data valid; instr_i sampled this cycle
//  instr_i        in   ADDRESS_WIDTH  fetched instruction
//  dmem_req_o     out  1   data memory request (load/store)
//  dmem_we_o      out  1   1 = store, 0 = load; valid with dmem_req_o
//  dmem_size_o    out  3   funct3 of load/store, valid with dmem_req_o
//  dmem_ack_i     in   1   data access complete
//  eq_i / lt_i / ltu_i  in 1 each  ALU flags: A==B, A<B signed, A<B unsigned
//  regWrite_en_o  out  1   register write enable (one-cycle pulse in WB)
//  ALUctrl_o      out  4   ALU op
//  ALUsrc_o       out  1   1 = immediate operand, 0 = register
//  IMMctrl_o      out  3   sign-extend format: I=000 S=001 B=010 U=011 J=100
//  PCsrc_o        out  2   00 = pc+4, 01 = pc+imm, 10 = rs1+imm (JALR)
//  pc_en_o        out  1   PC update strobe (one cycle per retired instruction)
//  trap_o         out  1   sticky trap flag
//  trap_cause_o   out  2   00 none, 01 illegal opcode/funct, 10 memory timeout
// BEHAVIOUR
//  - States: FETCH, DECODE, EXEC, MEM, WB, TRAP. rst_ni=0 at an edge -> state FETCH,
//    instr reg 0, wait counter 0, trap_o=0, trap_cause_o=00; all outputs forced 0 while rst_ni=0.
//  - Reset mid-operation (any state, incl. MEM with dmem_req_o high) aborts; no write/pc_en issued.
//  - FETCH: imem_req_o=1. Ack at edge -> latch instr_i, go DECODE. Else counter++.
//  - DECODE (1 cyc): opcode check; unknown opcode, R-type funct7 not 0000000/0100000, or
//    illegal funct3 (load 011/110/111, store >010, branch 010/011) -> TRAP, cause 01.
//  - EXEC (1 cyc): ALU/imm controls valid. R/I-ALU/LUI/AUIPC/JAL/JALR -> WB;
//    load/store -> MEM; branch -> FETCH with pc_en_o=1 this cycle.
//  - Branch taken: beq eq, bne !eq, blt lt, bge !lt, bltu ltu, bgeu !ltu -> PCsrc 01, else 00.
//  - MEM: dmem_req_o=1, dmem_we_o, dmem_size_o held stable until ack. Load+ack -> WB;
//    store+ack -> FETCH with pc_en_o=1 in the ack cycle.
//  - WB (1 cyc): regWrite_en_o=1, pc_en_o=1; PCsrc 01 for JAL, 10 for JALR, else 00 -> FETCH.
//  - ALUctrl: add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sltu 0110,
//    sll 0111, srl 1000, sra 1001, passB 1010 (LUI). Load/store/AUIPC/JAL/JALR use add.
//    Branches use sub (flags). I-type shifts: srai when instr[30]=1. ALUsrc=1 except R/branch.
//  - Timeout counter: 8 bit, cleared on entering FETCH/MEM and on ack. Reaching
//    MEM_TIMEOUT waiting cycles without ack -> TRAP cause 10; request drops same edge.
//    Ack arriving in the cycle counter==MEM_TIMEOUT-1 is accepted (ack has priority).
//  - TRAP: absorbing; all strobes 0, trap_o=1, cause held until reset.
//  - Latency with zero-wait ack: R/I/U/J 4 cycles, branch 3, store 4, load 5.
// TESTING
//  - add 0x002081B3, imem_ack immediate -> ALUctrl 0000, ALUsrc 0, regWrite pulse 4th cycle, pc_en same cycle.
//  - sub 0x402081B3 -> ALUctrl 0001; srai 0x4020D193 -> ALUctrl 1001, ALUsrc 1, IMMctrl 000.
//  - lw 0x0000A183, dmem_ack after 3 wait cycles -> dmem_req 4 cycles, we 0, size 010, then WB pulse.
//  - beq 0x00208463 eq_i=1 -> PCsrc 01, pc_en 1 in EXEC; eq_i=0 -> PCsrc 00; no regWrite.
//  - 0x0000007F -> trap_o=1, cause 01 after DECODE, stays through 20 further cycles.
//  - MEM_TIMEOUT=4, sw, dmem_ack never -> trap cause 10 after 4 MEM cycles; rst_ni=0 mid-MEM -> FETCH, no trap.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: RV32I multi-cycle control FSM.
// Sequences FETCH/DECODE/EXEC/MEM/WB with wait-state timeouts and a sticky trap.
module multicycle_control #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int MEM_TIMEOUT   = 15
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   output logic                     imem_req_o,
   input  logic                     imem_ack_i,
   input  logic [ADDRESS_WIDTH-1:0] instr_i,
   output logic                     dmem_req_o,
   output logic                     dmem_we_o,
   output logic [2:0]               dmem_size_o,
   input  logic                     dmem_ack_i,
   input  logic                     eq_i,
   input  logic                     lt_i,
   input  logic                     ltu_i,
   output logic                     regWrite_en_o,
   output logic [3:0]               ALUctrl_o,
   output logic                     ALUsrc_o,
   output logic [2:0]               IMMctrl_o,
   output logic [1:0]               PCsrc_o,
   output logic                     pc_en_o,
   output logic                     trap_o,
   output logic [1:0]               trap_cause_o
);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
   } state_t;

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LD    = 7'b0000011;
   localparam logic [6:0] OP_ST    = 7'b0100011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_REG   = 7'b0110011;
   localparam logic [6:0] OP_FENCE = 7'b0001111;
   localparam logic [6:0] OP_SYS   = 7'b1110011;

   localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

   state_t                   r_state, w_state_nxt;
   logic [ADDRESS_WIDTH-1:0] r_instr;
   logic [7:0]               r_cnt, w_cnt_nxt;
   logic [1:0]               r_cause, w_cause_nxt;
   logic                     w_instr_ld;

   logic [6:0] w_opc;
   logic [2:0] w_f3;
   logic [6:0] w_f7;
   logic       w_alt;
   logic       w_legal;
   logic       w_taken;
   logic       w_timeout;
   logic [3:0] w_alu;
   logic       w_src;
   logic [2:0] w_imm;
   logic       w_unused;

   assign w_opc     = r_instr[6:0];
   assign w_f3      = r_instr[14:12];
   assign w_f7      = r_instr[31:25];
   assign w_alt     = r_instr[30];
   assign w_timeout = (r_cnt == TO_LAST);
   assign w_unused  = ^{r_instr[24:15], r_instr[11:7]};

   // funct3 maps to the same op for R and I forms; only R uses bit 30 for sub
   function automatic logic [3:0] f_alu(input logic [2:0] f3,
                                        input logic alt,
                                        input logic is_reg);
      logic [3:0] op;
      unique case (f3)
         3'b000:  op = (is_reg && alt) ? 4'b0001 : 4'b0000;
         3'b001:  op = 4'b0111;
         3'b010:  op = 4'b0101;
         3'b011:  op = 4'b0110;
         3'b100:  op = 4'b0100;
         3'b101:  op = alt ? 4'b1001 : 4'b1000;
         3'b110:  op = 4'b0011;
         default: op = 4'b0010;
      endcase
      return op;
   endfunction

   always_comb begin
      w_alu = 4'b0000;
      w_src = 1'b1;
      w_imm = 3'b000;
      case (w_opc)
         OP_REG: begin
            w_alu = f_alu(w_f3, w_alt, 1'b1);
            w_src = 1'b0;
         end
         OP_IMM:   w_alu = f_alu(w_f3, w_alt, 1'b0);
         OP_LUI: begin
            w_alu = 4'b1010;
            w_imm = 3'b011;
         end
         OP_AUIPC: w_imm = 3'b011;
         OP_JAL:   w_imm = 3'b100;
         OP_BR: begin
            w_alu = 4'b0001;
            w_src = 1'b0;
            w_imm = 3'b010;
         end
         OP_ST:    w_imm = 3'b001;
         default:  w_alu = 4'b0000;
      endcase
   end

   always_comb begin
      w_legal = 1'b0;
      case (w_opc)
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
         OP_IMM, OP_FENCE, OP_SYS: w_legal = 1'b1;
         OP_REG: w_legal = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
         OP_LD:  w_legal = (w_f3 != 3'b011) && (w_f3 != 3'b110) &&
                           (w_f3 != 3'b111);
         OP_ST:  w_legal = (w_f3 <= 3'b010);
         OP_BR:  w_legal = (w_f3 != 3'b010) && (w_f3 != 3'b011);
         default: w_legal = 1'b0;
      endcase
   end

   always_comb begin
      case (w_f3)
         3'b000:  w_taken = eq_i;
         3'b001:  w_taken = !eq_i;
         3'b100:  w_taken = lt_i;
         3'b101:  w_taken = !lt_i;
         3'b110:  w_taken = ltu_i;
         3'b111:  w_taken = !ltu_i;
         default: w_taken = 1'b0;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cause_nxt = r_cause;
      w_instr_ld  = 1'b0;
      w_cnt_nxt   = 8'd0;
      case (r_state)
         S_FETCH: begin
            if (imem_ack_i) begin
               w_instr_ld  = 1'b1;
               w_state_nxt = S_DECODE;
            end else if (w_timeout) begin
               w_state_nxt = S_TRAP;
               w_cause_nxt = 2'b10;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         S_DECODE: begin
            if (w_legal) begin
               w_state_nxt = S_EXEC;
            end else begin
               w_state_nxt = S_TRAP;
               w_cause_nxt = 2'b01;
            end
         end
         S_EXEC: begin
            case (w_opc)
               OP_LD, OP_ST:            w_state_nxt = S_MEM;
               OP_BR, OP_FENCE, OP_SYS: w_state_nxt = S_FETCH;
               default:                 w_state_nxt = S_WB;
            endcase
         end
         S_MEM: begin
            if (dmem_ack_i) begin
               w_state_nxt = (w_opc == OP_LD) ? S_WB : S_FETCH;
            end else if (w_timeout) begin
               w_state_nxt = S_TRAP;
               w_cause_nxt = 2'b10;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         S_WB:    w_state_nxt = S_FETCH;
         default: w_state_nxt = S_TRAP;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state <= S_FETCH;
         r_instr <= '0;
         r_cnt   <= 8'd0;
         r_cause <= 2'b00;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_cause <= w_cause_nxt;
         if (w_instr_ld) r_instr <= instr_i;
      end
   end

   // every output is held low while reset is asserted
   always_comb begin
      imem_req_o    = 1'b0;
      dmem_req_o    = 1'b0;
      dmem_we_o     = 1'b0;
      dmem_size_o   = 3'b000;
      regWrite_en_o = 1'b0;
      ALUctrl_o     = 4'b0000;
      ALUsrc_o      = 1'b0;
      IMMctrl_o     = 3'b000;
      PCsrc_o       = 2'b00;
      pc_en_o       = 1'b0;
      trap_o        = 1'b0;
      trap_cause_o  = 2'b00;
      if (rst_ni) begin
         ALUctrl_o    = w_alu;
         ALUsrc_o     = w_src;
         IMMctrl_o    = w_imm;
         trap_cause_o = r_cause;
         case (r_state)
            S_FETCH: imem_req_o = 1'b1;
            S_EXEC: begin
               if (w_opc == OP_BR) begin
                  pc_en_o = 1'b1;
                  PCsrc_o = w_taken ? 2'b01 : 2'b00;
               end else if (w_opc == OP_FENCE || w_opc == OP_SYS) begin
                  pc_en_o = 1'b1;
               end
            end
            S_MEM: begin
               dmem_req_o  = 1'b1;
               dmem_we_o   = (w_opc == OP_ST);
               dmem_size_o = w_f3;
               pc_en_o     = dmem_ack_i && (w_opc == OP_ST);
            end
            S_WB: begin
               regWrite_en_o = 1'b1;
               pc_en_o       = 1'b1;
               if (w_opc == OP_JAL)       PCsrc_o = 2'b01;
               else if (w_opc == OP_JALR) PCsrc_o = 2'b10;
            end
            S_TRAP:  trap_o = 1'b1;
            default: trap_o = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench for multicycle_control.
// Per-cycle expected output vectors are queued by the driver and popped at negedge.
module tb_multicycle_control;

   typedef enum int {K_WB, K_JAL, K_JALR, K_BR, K_LD, K_ST, K_ILL} kind_t;

   typedef struct {
      string       nm;
      logic [31:0] ins;
      logic [2:0]  flg;
      int          iw;
      int          dw;
      kind_t       k;
      logic [3:0]  alu;
      logic        src;
      logic [2:0]  imm;
      logic        ck_imm;
      logic        tk;
   } vec_t;

   typedef struct {
      string       tag;
      logic [20:0] val;
      logic [20:0] mask;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_ack, dmem_ack;
   logic [31:0] instr;
   logic        eq, lt, ltu;
   logic        imem_req, dmem_req, dmem_we, rw, alusrc, pc_en, trap;
   logic [2:0]  dmem_size, immctrl;
   logic [3:0]  aluctrl;
   logic [1:0]  pcsrc, cause;

   exp_t        sb[$];
   int          n_tot = 0;
   int          n_bad = 0;
   logic        done = 1'b0;
   logic        drained = 1'b0;

   logic [20:0] M_BASE, M_ALU, M_NOIMM, M_PCS, M_DM, M_ALL;

   always #5 clk = ~clk;

   multicycle_control #(.ADDRESS_WIDTH(32), .MEM_TIMEOUT(4)) dut (
      .clk_i(clk),           .rst_ni(rst_n),
      .imem_req_o(imem_req), .imem_ack_i(imem_ack),
      .instr_i(instr),
      .dmem_req_o(dmem_req), .dmem_we_o(dmem_we),
      .dmem_size_o(dmem_size), .dmem_ack_i(dmem_ack),
      .eq_i(eq), .lt_i(lt), .ltu_i(ltu),
      .regWrite_en_o(rw),    .ALUctrl_o(aluctrl),
      .ALUsrc_o(alusrc),     .IMMctrl_o(immctrl),
      .PCsrc_o(pcsrc),       .pc_en_o(pc_en),
      .trap_o(trap),         .trap_cause_o(cause)
   );

   function automatic logic [20:0] pk(
      input logic im, input logic dm, input logic we, input logic [2:0] sz,
      input logic w, input logic [3:0] al, input logic sr, input logic [2:0] ic,
      input logic [1:0] ps, input logic pe, input logic tr, input logic [1:0] ca);
      return {im, dm, we, sz, w, al, sr, ic, ps, pe, tr, ca};
   endfunction

   task automatic check(input string tag, input logic [20:0] obs,
                        input logic [20:0] exp);
      n_tot++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check(e.tag,
               pk(imem_req, dmem_req, dmem_we, dmem_size, rw, aluctrl, alusrc,
                  immctrl, pcsrc, pc_en, trap, cause) & e.mask,
               e.val & e.mask);
      end else if (done && !drained) begin
         drained = 1'b1;
         check("drain", 21'(sb.size()), 21'd0);
      end
   end

   task automatic step(input string tag, input logic [20:0] v,
                       input logic [20:0] m);
      exp_t e;
      e.tag  = tag;
      e.val  = v;
      e.mask = m;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst_n    = 1'b0;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      for (int i = 0; i < n; i++) step("rst", 21'd0, M_ALL);
      rst_n = 1'b1;
   endtask

   task automatic run(input vec_t v);
      logic [20:0] m;
      logic [1:0]  ps;
      instr         = v.ins;
      {eq, lt, ltu} = v.flg;
      for (int k = 0; k <= v.iw; k++) begin
         imem_ack = (k == v.iw);
         step({v.nm, ".if"}, pk(1,0,0,0,0,0,0,0,0,0,0,0), M_BASE);
      end
      imem_ack = 1'b0;
      step({v.nm, ".id"}, 21'd0, M_BASE);
      if (v.k == K_ILL) begin
         for (int i = 0; i < 20; i++)
            step({v.nm, ".trap"}, pk(0,0,0,0,0,0,0,0,0,0,1,2'b01), M_BASE);
         do_reset(2);
         return;
      end
      m = M_BASE | (v.ck_imm ? M_ALU : M_NOIMM);
      if (v.k == K_BR) begin
         ps = v.tk ? 2'b01 : 2'b00;
         step({v.nm, ".ex"}, pk(0,0,0,0,0,v.alu,v.src,v.imm,ps,1,0,0),
              m | M_PCS);
         return;
      end
      step({v.nm, ".ex"}, pk(0,0,0,0,0,v.alu,v.src,v.imm,0,0,0,0), m);
      if (v.k == K_LD || v.k == K_ST) begin
         for (int k = 0; k < 4; k++) begin
            logic st, ack;
            if (v.dw == -2 && k == 2) begin
               do_reset(1);
               step({v.nm, ".rfetch"}, pk(1,0,0,0,0,0,0,0,0,0,0,0), M_BASE);
               return;
            end
            st  = (v.k == K_ST);
            ack = (k == v.dw);
            dmem_ack = ack;
            step({v.nm, ".mem"},
                 pk(0,1,st,v.ins[14:12],0,0,0,0,0,st && ack,0,0),
                 M_BASE | M_DM | ((st && ack) ? M_PCS : 21'd0));
            if (ack) break;
         end
         dmem_ack = 1'b0;
         if (v.dw < 0) begin
            for (int i = 0; i < 3; i++)
               step({v.nm, ".to"}, pk(0,0,0,0,0,0,0,0,0,0,1,2'b10), M_BASE);
            do_reset(2);
            return;
         end
         if (v.k == K_ST) return;
      end
      ps = (v.k == K_JAL) ? 2'b01 : (v.k == K_JALR) ? 2'b10 : 2'b00;
      step({v.nm, ".wb"}, pk(0,0,0,0,1,0,0,0,ps,1,0,0), M_BASE | M_PCS);
   endtask

   function automatic vec_t mk(
      input string nm, input logic [31:0] ins, input logic [2:0] flg,
      input int iw, input int dw, input kind_t k, input logic [3:0] alu,
      input logic src, input logic [2:0] imm, input logic ck_imm,
      input logic tk);
      vec_t v;
      v.nm = nm; v.ins = ins; v.flg = flg; v.iw = iw; v.dw = dw; v.k = k;
      v.alu = alu; v.src = src; v.imm = imm; v.ck_imm = ck_imm; v.tk = tk;
      return v;
   endfunction

   initial begin
      vec_t tbl[$];
      M_BASE  = pk(1,1,0,3'd0,1,4'd0,0,3'd0,2'd0,1,1,2'd3);
      M_ALU   = pk(0,0,0,3'd0,0,4'hF,1,3'd7,2'd0,0,0,2'd0);
      M_NOIMM = pk(0,0,0,3'd0,0,4'hF,1,3'd0,2'd0,0,0,2'd0);
      M_PCS   = pk(0,0,0,3'd0,0,4'd0,0,3'd0,2'd3,0,0,2'd0);
      M_DM    = pk(0,0,1,3'd7,0,4'd0,0,3'd0,2'd0,0,0,2'd0);
      M_ALL   = 21'h1FFFFF;

      //            name     instr         flg  iw dw  kind    alu      src imm  ckI tk
      tbl.push_back(mk("add",  32'h002081B3, 3'b000, 0, 0, K_WB,  4'b0000, 0, 3'b000, 0, 0));
      tbl.push_back(mk("sub",  32'h402081B3, 3'b000, 2, 0, K_WB,  4'b0001, 0, 3'b000, 0, 0));
      tbl.push_back(mk("srai", 32'h4020D193, 3'b000, 0, 0, K_WB,  4'b1001, 1, 3'b000, 1, 0));
      tbl.push_back(mk("lw",   32'h0000A183, 3'b000, 0, 3, K_LD,  4'b0000, 1, 3'b000, 1, 0));
      tbl.push_back(mk("beqT", 32'h00208463, 3'b100, 0, 0, K_BR,  4'b0001, 0, 3'b010, 1, 1));
      tbl.push_back(mk("beqN", 32'h00208463, 3'b011, 0, 0, K_BR,  4'b0001, 0, 3'b010, 1, 0));
      tbl.push_back(mk("bgeN", 32'h0020D463, 3'b010, 0, 0, K_BR,  4'b0001, 0, 3'b010, 1, 0));
      tbl.push_back(mk("bgeT", 32'h0020D463, 3'b001, 0, 0, K_BR,  4'b0001, 0, 3'b010, 1, 1));
      tbl.push_back(mk("sw",   32'h0020A023, 3'b000, 1, 0, K_ST,  4'b0000, 1, 3'b001, 1, 0));
      tbl.push_back(mk("lui",  32'h123450B7, 3'b000, 0, 0, K_WB,  4'b1010, 1, 3'b011, 1, 0));
      tbl.push_back(mk("auipc",32'h00001097, 3'b000, 0, 0, K_WB,  4'b0000, 1, 3'b011, 1, 0));
      tbl.push_back(mk("jal",  32'h008000EF, 3'b000, 3, 0, K_JAL, 4'b0000, 1, 3'b100, 1, 0));
      tbl.push_back(mk("jalr", 32'h000080E7, 3'b000, 0, 0, K_JALR,4'b0000, 1, 3'b000, 1, 0));
      tbl.push_back(mk("ill",  32'h0000007F, 3'b000, 0, 0, K_ILL, 4'b0000, 0, 3'b000, 0, 0));
      tbl.push_back(mk("badf7",32'h202081B3, 3'b000, 0, 0, K_ILL, 4'b0000, 0, 3'b000, 0, 0));
      tbl.push_back(mk("badld",32'h0000B183, 3'b000, 0, 0, K_ILL, 4'b0000, 0, 3'b000, 0, 0));
      tbl.push_back(mk("swTO", 32'h0020A023, 3'b000, 0, -1,K_ST,  4'b0000, 1, 3'b001, 1, 0));
      tbl.push_back(mk("swRst",32'h0020A023, 3'b000, 0, -2,K_ST,  4'b0000, 1, 3'b001, 1, 0));
      tbl.push_back(mk("add2", 32'h002081B3, 3'b000, 0, 0, K_WB,  4'b0000, 0, 3'b000, 0, 0));

      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      instr    = 32'd0;
      {eq, lt, ltu} = 3'b000;
      rst_n    = 1'b0;
      @(posedge clk);
      #1;
      do_reset(2);
      foreach (tbl[i]) run(tbl[i]);
      done = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      if (!drained) begin
         n_tot++;
         n_bad++;
         $display("FAIL drain obs=missing exp=done");
      end
      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
